// File: rtl/fp_max_prep.sv
// Two-stage operand preparation for the FP min/max selector.
//
// S1 registers the raw operands, whether each single-precision operand failed
// its NaN-box check, and the fmt/rm/tag fields. S2 registers the canonicalised
// operands, their one-hot class vectors and 65-bit sign/magnitude compare keys.
// All outputs come straight from S2 registers.
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   flush                drop every in-flight operation
//   in_valid/in_ready    input handshake; in_ready never depends on in_valid
//   in_data1/2, in_fmt   raw operands and format (0 = single, else double)
//   in_rm, in_tag        passed through
//   out_valid/out_ready  output handshake
//   out_data1/2          operands after NaN-box canonicalisation
//   out_ext1/2           {sign, zero-extended magnitude} compare keys
//   out_class1/2         one-hot class (see classify)
//   out_fmt/rm/tag       passed through
module fp_max_prep #(
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_data1,
  input  logic [63:0]      in_data2,
  input  logic [1:0]       in_fmt,
  input  logic [2:0]       in_rm,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_data1,
  output logic [63:0]      out_data2,
  output logic [64:0]      out_ext1,
  output logic [64:0]      out_ext2,
  output logic [9:0]       out_class1,
  output logic [9:0]       out_class2,
  output logic [1:0]       out_fmt,
  output logic [2:0]       out_rm,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [63:0] CanonNan = 64'hFFFF_FFFF_7FC0_0000;

  // Class bit order: -inf, -norm, -sub, -0, +0, +sub, +norm, +inf, sNaN, qNaN
  function automatic logic [9:0] classify(input logic [63:0] d, input logic single);
    logic sign, exp_ones, exp_zero, man_zero, man_msb;
    logic [9:0] c;
    if (single) begin
      sign     = d[31];
      exp_ones = &d[30:23];
      exp_zero = ~|d[30:23];
      man_zero = ~|d[22:0];
      man_msb  = d[22];
    end else begin
      sign     = d[63];
      exp_ones = &d[62:52];
      exp_zero = ~|d[62:52];
      man_zero = ~|d[51:0];
      man_msb  = d[51];
    end
    c = '0;
    if (exp_ones) begin
      if (man_zero) begin
        if (sign) c[0] = 1'b1;
        else      c[7] = 1'b1;
      end else if (man_msb) begin
        c[9] = 1'b1;
      end else begin
        c[8] = 1'b1;
      end
    end else if (exp_zero) begin
      if (man_zero) begin
        if (sign) c[3] = 1'b1;
        else      c[4] = 1'b1;
      end else begin
        if (sign) c[2] = 1'b1;
        else      c[5] = 1'b1;
      end
    end else begin
      if (sign) c[1] = 1'b1;
      else      c[6] = 1'b1;
    end
    return c;
  endfunction

  // Sign on top, magnitude below: unsigned compare of [63:0] orders magnitudes.
  function automatic logic [64:0] ext_key(input logic [63:0] d, input logic single);
    if (single) return {d[31], 33'b0, d[30:0]};
    return {d[63], 1'b0, d[62:0]};
  endfunction

  // Stage 1 state
  logic             s1_valid_q, s1_valid_d;
  logic [63:0]      s1_data1_q, s1_data2_q;
  logic             s1_unboxed1_q, s1_unboxed2_q;
  logic [1:0]       s1_fmt_q;
  logic [2:0]       s1_rm_q;
  logic [TAG_W-1:0] s1_tag_q;

  // Stage 2 state
  logic             s2_valid_q, s2_valid_d;
  logic [63:0]      s2_data1_q, s2_data2_q;
  logic [64:0]      s2_ext1_q, s2_ext2_q;
  logic [9:0]       s2_class1_q, s2_class2_q;
  logic [1:0]       s2_fmt_q;
  logic [2:0]       s2_rm_q;
  logic [TAG_W-1:0] s2_tag_q;

  logic        s1_advance, s2_advance, in_fire, s2_load;
  logic        in_single, s1_single;
  logic        in_unboxed1, in_unboxed2;
  logic [63:0] s1_canon1, s1_canon2;

  assign s2_advance = !s2_valid_q || out_ready;
  assign s1_advance = !s1_valid_q || s2_advance;
  assign in_ready   = !flush && s1_advance;
  assign in_fire    = in_valid && in_ready;
  assign s2_load    = s1_valid_q && s2_advance && !flush;

  assign in_single   = (in_fmt == 2'd0);
  assign in_unboxed1 = in_single && (in_data1[63:32] != 32'hFFFF_FFFF);
  assign in_unboxed2 = in_single && (in_data2[63:32] != 32'hFFFF_FFFF);

  assign s1_single = (s1_fmt_q == 2'd0);
  assign s1_canon1 = s1_unboxed1_q ? CanonNan : s1_data1_q;
  assign s1_canon2 = s1_unboxed2_q ? CanonNan : s1_data2_q;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    if (flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end else begin
      if (s1_advance) s1_valid_d = in_valid;
      if (s2_advance) s2_valid_d = s1_valid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q    <= 1'b0;
      s1_data1_q    <= '0;
      s1_data2_q    <= '0;
      s1_unboxed1_q <= 1'b0;
      s1_unboxed2_q <= 1'b0;
      s1_fmt_q      <= '0;
      s1_rm_q       <= '0;
      s1_tag_q      <= '0;
      s2_valid_q    <= 1'b0;
      s2_data1_q    <= '0;
      s2_data2_q    <= '0;
      s2_ext1_q     <= '0;
      s2_ext2_q     <= '0;
      s2_class1_q   <= '0;
      s2_class2_q   <= '0;
      s2_fmt_q      <= '0;
      s2_rm_q       <= '0;
      s2_tag_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      if (in_fire) begin
        s1_data1_q    <= in_data1;
        s1_data2_q    <= in_data2;
        s1_unboxed1_q <= in_unboxed1;
        s1_unboxed2_q <= in_unboxed2;
        s1_fmt_q      <= in_fmt;
        s1_rm_q       <= in_rm;
        s1_tag_q      <= in_tag;
      end
      if (s2_load) begin
        s2_data1_q  <= s1_canon1;
        s2_data2_q  <= s1_canon2;
        s2_ext1_q   <= ext_key(s1_canon1, s1_single);
        s2_ext2_q   <= ext_key(s1_canon2, s1_single);
        s2_class1_q <= classify(s1_canon1, s1_single);
        s2_class2_q <= classify(s1_canon2, s1_single);
        s2_fmt_q    <= s1_fmt_q;
        s2_rm_q     <= s1_rm_q;
        s2_tag_q    <= s1_tag_q;
      end
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_data1  = s2_data1_q;
  assign out_data2  = s2_data2_q;
  assign out_ext1   = s2_ext1_q;
  assign out_ext2   = s2_ext2_q;
  assign out_class1 = s2_class1_q;
  assign out_class2 = s2_class2_q;
  assign out_fmt    = s2_fmt_q;
  assign out_rm     = s2_rm_q;
  assign out_tag    = s2_tag_q;

endmodule

// File: tb/tb_fp_max_prep.sv
module tb_fp_max_prep;

  localparam int TagW = 5;

  logic            clk = 1'b0;
  logic            rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [63:0]     in_data1, in_data2, out_data1, out_data2;
  logic [1:0]      in_fmt, out_fmt;
  logic [2:0]      in_rm, out_rm;
  logic [TagW-1:0] in_tag, out_tag;
  logic [64:0]     out_ext1, out_ext2;
  logic [9:0]      out_class1, out_class2;

  always #5 clk = ~clk;

  fp_max_prep #(.TAG_W(TagW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data1(in_data1), .in_data2(in_data2),
    .in_fmt(in_fmt), .in_rm(in_rm), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data1(out_data1), .out_data2(out_data2),
    .out_ext1(out_ext1), .out_ext2(out_ext2),
    .out_class1(out_class1), .out_class2(out_class2),
    .out_fmt(out_fmt), .out_rm(out_rm), .out_tag(out_tag)
  );

  typedef struct {
    logic [63:0]     d1, d2;
    logic [64:0]     e1, e2;
    logic [9:0]      c1, c2;
    logic [1:0]      fmt;
    logic [2:0]      rm;
    logic [TagW-1:0] tag;
  } bundle_t;

  typedef struct {
    bundle_t b;
    bit      aged;
  } entry_t;

  typedef struct {
    logic [63:0] a, b;
    logic [1:0]  fmt;
    logic [63:0] xd1, xd2;
    logic [9:0]  xc1, xc2;
    logic [64:0] xe1, xe2;
  } vec_t;

  int      n_checks = 0;
  int      n_fail   = 0;
  entry_t  sb[$];
  logic [TagW-1:0] got_tags[$];
  bit      post_reset = 0;
  bit      last_in_acc = 0;
  bit      saw_ir_low = 0;
  bit      collect = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model from the format rules
  function automatic logic [63:0] canon(input logic [63:0] d, input logic [1:0] fmt);
    if (fmt == 2'd0 && d[63:32] != 32'hFFFF_FFFF) return 64'hFFFF_FFFF_7FC0_0000;
    return d;
  endfunction

  function automatic logic [9:0] cls(input logic [63:0] d, input bit sgl);
    int unsigned e, emax;
    longint unsigned m, qbit;
    bit s;
    int idx;
    if (sgl) begin
      s = d[31]; e = 32'(d[30:23]); emax = 255; m = 64'(d[22:0]); qbit = 64'd1 << 22;
    end else begin
      s = d[63]; e = 32'(d[62:52]); emax = 2047; m = 64'(d[51:0]); qbit = 64'd1 << 51;
    end
    if (e == emax) idx = (m == 0) ? (s ? 0 : 7) : (((m & qbit) != 0) ? 9 : 8);
    else if (e == 0) idx = (m == 0) ? (s ? 3 : 4) : (s ? 2 : 5);
    else idx = s ? 1 : 6;
    return 10'd1 << idx;
  endfunction

  function automatic logic [64:0] key(input logic [63:0] d, input bit sgl);
    if (sgl) return {d[31], 64'(d[30:0])};
    return {d[63], 64'(d[62:0])};
  endfunction

  function automatic bundle_t model(input logic [63:0] a, input logic [63:0] b,
                                    input logic [1:0] fmt, input logic [2:0] rm,
                                    input logic [TagW-1:0] tag);
    bundle_t r;
    bit sgl = (fmt == 2'd0);
    r.d1 = canon(a, fmt);     r.d2 = canon(b, fmt);
    r.c1 = cls(r.d1, sgl);    r.c2 = cls(r.d2, sgl);
    r.e1 = key(r.d1, sgl);    r.e2 = key(r.d2, sgl);
    r.fmt = fmt; r.rm = rm; r.tag = tag;
    return r;
  endfunction

  function automatic logic [63:0] rand_op();
    logic [31:0] s;
    logic [63:0] d;
    case ($urandom_range(0, 5))
      0: return {$urandom, $urandom};
      1: return {32'hFFFF_FFFF, $urandom};
      2: begin
        s = {$urandom_range(0, 1) == 1, ($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00, 23'd0};
        case ($urandom_range(0, 2))
          0: s[22:0] = 23'd0;
          1: s[22] = 1'b1;
          default: s[0] = 1'b1;
        endcase
        return {32'hFFFF_FFFF, s};
      end
      default: begin
        d = {$urandom_range(0, 1) == 1, ($urandom_range(0, 1) == 1) ? 11'h7FF : 11'h000, 52'd0};
        case ($urandom_range(0, 2))
          0: d[51:0] = 52'd0;
          1: d[51] = 1'b1;
          default: d[3] = 1'b1;
        endcase
        return d;
      end
    endcase
  endfunction

  // One clock cycle: check at negedge, advance the model at posedge.
  task automatic step();
    bit exp_ov, exp_ir, in_acc, out_acc;
    bundle_t f;
    exp_ir = 1'b0;
    @(negedge clk);
    exp_ov = (sb.size() > 0) && sb[0].aged;
    if (rst_n) begin
      if (post_reset) begin
        chk("rst_out_data1", 128'(out_data1), 128'(0));
        chk("rst_out_data2", 128'(out_data2), 128'(0));
        chk("rst_out_ext1", 128'(out_ext1), 128'(0));
        chk("rst_out_ext2", 128'(out_ext2), 128'(0));
        chk("rst_out_class", 128'({out_class1, out_class2}), 128'(0));
        chk("rst_out_fmt_rm_tag", 128'({out_fmt, out_rm, out_tag}), 128'(0));
      end
      exp_ir = !flush && (sb.size() < 2 || out_ready);
      chk("out_valid", 128'(out_valid), 128'(exp_ov));
      chk("in_ready", 128'(in_ready), 128'(exp_ir));
      if (!in_ready) saw_ir_low = 1;
      if (exp_ov) begin
        f = sb[0].b;
        chk("out_data1", 128'(out_data1), 128'(f.d1));
        chk("out_data2", 128'(out_data2), 128'(f.d2));
        chk("out_ext1", 128'(out_ext1), 128'(f.e1));
        chk("out_ext2", 128'(out_ext2), 128'(f.e2));
        chk("out_class1", 128'(out_class1), 128'(f.c1));
        chk("out_class2", 128'(out_class2), 128'(f.c2));
        chk("out_fmt_rm_tag", 128'({out_fmt, out_rm, out_tag}), 128'({f.fmt, f.rm, f.tag}));
      end
      if (collect && out_valid && out_ready && !flush) got_tags.push_back(out_tag);
    end
    in_acc  = rst_n && !flush && in_valid && exp_ir;
    out_acc = rst_n && !flush && exp_ov && out_ready;
    @(posedge clk);
    post_reset  = !rst_n;
    last_in_acc = in_acc;
    if (!rst_n || flush) begin
      sb.delete();
    end else begin
      foreach (sb[i]) sb[i].aged = 1;
      if (out_acc) void'(sb.pop_front());
      if (in_acc) sb.push_back('{b: model(in_data1, in_data2, in_fmt, in_rm, in_tag), aged: 0});
    end
    #1;
  endtask

  task automatic drive_rand(input logic [TagW-1:0] tag);
    in_data1 = rand_op();
    in_data2 = rand_op();
    in_fmt   = 2'($urandom_range(0, 3));
    in_rm    = 3'($urandom_range(0, 7));
    in_tag   = tag;
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{64'h3FF0000000000000, 64'hBFF0000000000000, 2'd1,
                64'h3FF0000000000000, 64'hBFF0000000000000, 10'h040, 10'h002,
                {1'b0, 64'h3FF0000000000000}, {1'b1, 64'h3FF0000000000000}};
    vecs[1] = '{64'hFFFFFFFF80000000, 64'hFFFFFFFF7F800001, 2'd0,
                64'hFFFFFFFF80000000, 64'hFFFFFFFF7F800001, 10'h008, 10'h100,
                {1'b1, 64'h0}, {1'b0, 64'h7F800001}};
    vecs[2] = '{64'h0000000040000000, 64'hFFFFFFFF00000001, 2'd0,
                64'hFFFFFFFF7FC00000, 64'hFFFFFFFF00000001, 10'h200, 10'h020,
                {1'b0, 64'h7FC00000}, {1'b0, 64'h1}};
    vecs[3] = '{64'hFFF0000000000000, 64'h7FF8000000000000, 2'd1,
                64'hFFF0000000000000, 64'h7FF8000000000000, 10'h001, 10'h200,
                {1'b1, 64'h7FF0000000000000}, {1'b0, 64'h7FF8000000000000}};
    vecs[4] = '{64'h800FFFFFFFFFFFFF, 64'h0000000000000000, 2'd2,
                64'h800FFFFFFFFFFFFF, 64'h0000000000000000, 10'h004, 10'h010,
                {1'b1, 64'h000FFFFFFFFFFFFF}, {1'b0, 64'h0}};
    vecs[5] = '{64'hFFFFFFFF7F800000, 64'hFFFFFFFFC0490FDB, 2'd0,
                64'hFFFFFFFF7F800000, 64'hFFFFFFFFC0490FDB, 10'h080, 10'h002,
                {1'b0, 64'h7F800000}, {1'b1, 64'h40490FDB}};
    vecs[6] = '{64'h000000003F800000, 64'h7FF0000000000001, 2'd3,
                64'h000000003F800000, 64'h7FF0000000000001, 10'h020, 10'h100,
                {1'b0, 64'h000000003F800000}, {1'b0, 64'h7FF0000000000001}};

    rst_n = 0; flush = 0; in_valid = 0; out_ready = 1;
    in_data1 = '0; in_data2 = '0; in_fmt = '0; in_rm = '0; in_tag = '0;
    repeat (2) step();
    rst_n = 1;
    step();

    // Directed vectors: accept, then look at the output two edges later.
    foreach (vecs[i]) begin
      in_valid = 1; in_data1 = vecs[i].a; in_data2 = vecs[i].b; in_fmt = vecs[i].fmt;
      in_rm = 3'd1; in_tag = TagW'(i + 3);
      step();
      chk("vec_accept", 128'(last_in_acc), 128'(1));
      in_valid = 0;
      step();
      #2;
      chk("vec_out_valid", 128'(out_valid), 128'(1));
      chk("vec_data1", 128'(out_data1), 128'(vecs[i].xd1));
      chk("vec_data2", 128'(out_data2), 128'(vecs[i].xd2));
      chk("vec_class1", 128'(out_class1), 128'(vecs[i].xc1));
      chk("vec_class2", 128'(out_class2), 128'(vecs[i].xc2));
      chk("vec_ext1", 128'(out_ext1), 128'(vecs[i].xe1));
      chk("vec_ext2", 128'(out_ext2), 128'(vecs[i].xe2));
      chk("vec_tag_rm", 128'({out_tag, out_rm}), 128'({TagW'(i + 3), 3'd1}));
      step();
    end

    // Stream tags 1..6 with the consumer stalled on cycles 2..5.
    begin
      int k = 1;
      saw_ir_low = 0; collect = 1; got_tags.delete();
      for (int cyc = 1; cyc <= 40 && got_tags.size() < 6; cyc++) begin
        in_valid  = (k <= 6);
        drive_rand(TagW'(k));
        out_ready = !(cyc >= 2 && cyc <= 5);
        step();
        if (last_in_acc) k++;
      end
      in_valid = 0; out_ready = 1; collect = 0;
      chk("stall_in_ready_drop", 128'(saw_ir_low), 128'(1));
      chk("stall_count", 128'(got_tags.size()), 128'(6));
      foreach (got_tags[i]) chk("stall_order", 128'(got_tags[i]), 128'(i + 1));
    end

    // Flush with two operations held and a simultaneous input.
    out_ready = 0; in_valid = 1;
    for (int i = 0; i < 3; i++) begin drive_rand(TagW'(10 + i)); step(); end
    chk("flush_full", 128'(sb.size()), 128'(2));
    flush = 1; drive_rand(TagW'(20));
    step();
    chk("flush_no_accept", 128'(last_in_acc), 128'(0));
    flush = 0; in_valid = 0; out_ready = 1;
    step();
    in_valid = 1; drive_rand(TagW'(21));
    step();
    in_valid = 0;
    repeat (3) step();

    // Reset while stalled with two held.
    out_ready = 0; in_valid = 1;
    for (int i = 0; i < 3; i++) begin drive_rand(TagW'(24 + i)); step(); end
    in_valid = 0; rst_n = 0;
    step();
    rst_n = 1;
    step();
    out_ready = 1;
    step();

    // Random traffic against the scoreboard.
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 49) == 0);
      drive_rand(TagW'($urandom));
      step();
    end
    flush = 0; in_valid = 0; out_ready = 1;
    repeat (4) step();
    chk("drain_empty", 128'(sb.size()), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_max_prep.md
# fp_max_prep

Two-stage pipelined operand-preparation stage that feeds the floating-point min/max selector. It accepts raw operand pairs with a valid/ready handshake and classifies each operand into the 10-bit one-hot class vector. It also builds the 65-bit sign/magnitude compare keys and applies NaN-boxing checks to single-precision inputs. The result is presented as the selector's input bundle. It sits between the FPU issue/operand-read logic and the combinational min/max selector.

## Interface
- TAG_W, 5, width of the opaque tag carried alongside each operation (destination register id)
- clk  input  1  clock
- rst_n  input  1  reset, synchronous, active-low
- flush  input  1  kill all in-flight operations
- in_valid  input  1  input operation valid
- in_ready  output  1  stage can accept input this cycle
- in_data1  input  64  operand 1 (single precision in [31:0], NaN-boxed)
- in_data2  input  64  operand 2
- in_fmt  input  2  0 = single, 1 = double; other values are treated as double
- in_rm  input  3  0 = min, 1 = max; passed through unchanged
- in_tag  input  TAG_W  passed through
- out_valid  output  1  output bundle valid
- out_ready  input  1  consumer accepts output
- out_data1, out_data2  output  64  operands after NaN-box canonicalisation
- out_ext1, out_ext2  output  65  compare keys
- out_class1, out_class2  output  10  one-hot class
- out_fmt  output  2; out_rm  output  3; out_tag  output  TAG_W  passed through

## Operation
- Stage 1 (S1) registers the raw inputs, the NaN-box check result and the fmt/rm/tag fields. Stage 2 (S2) registers the class vectors and ext keys. The outputs are driven directly from S2 registers.
- NaN-box rule: for fmt==0, if data[63:32] != 32'hFFFFFFFF, the operand is replaced by 64'hFFFFFFFF7FC00000 (canonical qNaN) before classification. For other fmt values the data passes unchanged.
- Field extraction:
  - Single: sign = [31], exponent = [30:23], mantissa = [22:0].
  - Double: sign = [63], exponent = [62:52], mantissa = [51:0].
- Class bits:
  - 0: −inf
  - 1: −normal
  - 2: −subnormal
  - 3: −0
  - 4: +0
  - 5: +subnormal
  - 6: +normal
  - 7: +inf
  - 8: sNaN (exponent all ones, mantissa nonzero, mantissa MSB = 0)
  - 9: qNaN (mantissa MSB = 1)
  - Exactly one bit is set.
- ext[64] = sign.
  - Single: ext[63:0] = {33'b0, data[30:0]}.
  - Double: ext[63:0] = {1'b0, data[62:0]}.
  - An unsigned compare of ext[63:0] therefore orders magnitudes.
- The class and ext for each operand are computed from the canonicalised data, so out_data reflects any NaN-box replacement.

## Timing
- Latency is 2 cycles: an input accepted at edge N appears with out_valid at edge N+2 when there is no stall.
- Throughput is 1 operation per cycle.
- Handshake and stage advance:
  - A transfer occurs when valid && ready are both high at a rising edge.
  - Each stage advances when it is empty or the downstream stage advances (bubble-collapsing).
  - in_ready = !flush && (!s1_valid || s2_advance), where s2_advance = !s2_valid || out_ready.
  - in_ready depends combinationally on out_ready. There is no path from in_valid to in_ready.
- Holding rules:
  - While out_valid && !out_ready, all out_* signals are held stable.
  - S1 holds when S2 cannot accept.
  - Ordering is strictly FIFO.
- Reset (rst_n low at an edge): s1_valid and s2_valid go to 0 and all payload registers go to 0. After reset, out_valid = 0, in_ready = 1, and all data, ext, class, fmt, rm and tag outputs are 0.
- flush high at an edge clears both valid bits. Payload registers are don't-care.
  - flush takes priority over a simultaneous input handshake; in_ready is low while flush is high, so no input is accepted.
  - flush also takes priority over an output transfer that edge; the consumer must not treat out_valid && out_ready as consumed when flush is high.
- Reset applied mid-stall discards all held operations. There is no pending state beyond the two stages, so capacity is 2 operations.

## Test plan
- Double operands 3FF0000000000000 and BFF0000000000000 with fmt=1, rm=1, out_ready=1 → two cycles later out_class1=10'h040, out_class2=10'h002, out_ext1={1'b0,64'h3FF0000000000000}, out_ext2={1'b1,64'h3FF0000000000000}, with the tag echoed.
- Single operands FFFFFFFF80000000 and FFFFFFFF7F800001 with fmt=0 → out_class1=10'h008 and out_ext1={1'b1,64'h0}; out_class2=10'h100 and out_ext2[63:0]=64'h7F800001.
- Unboxed single 0000000040000000 paired with a boxed FFFFFFFF00000001 → out_data1=FFFFFFFF7FC00000, out_class1=10'h200; out_class2=10'h020.
- Back-to-back stream of tags 1..6 with out_ready held low for cycles 2–5 → in_ready drops once 2 operations are held; the output stays stable on tag 1; tags 1..6 emerge in order with no loss or duplication.
- flush asserted together with in_valid while 2 operations are held → in_ready=0 that cycle; out_valid=0 on the next cycle; the subsequent input appears 2 cycles after its own acceptance.
- rst_n low for 1 cycle while stalled with 2 operations held → out_valid=0, in_ready=1 and all outputs 0 on the next cycle.
